intu_warp_sequencer: RTL and testbench



---
 rtl/intu_warp_sequencer.sv | 107 ++++++++++
 tb/tb_intu_warp_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/intu_warp_sequencer.sv
// Runs one warp instruction through NUM_LANES INT lanes, one non-empty thread group per cycle, then holds the gathered result.
// Latency k+1 cycles (k = non-empty groups); no input accepted outside IDLE, DONE holds until wb_ready_i.
module intu_warp_sequencer #(
   parameter int WARP_SIZE = 32,
   parameter int NUM_LANES = 8,
   parameter int DATA_W    = 32,
   parameter int CTRL_W    = 64
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            issue_valid_i,
   output logic                            issue_ready_o,
   input  logic [WARP_SIZE-1:0]            issue_mask_i,
   input  logic [CTRL_W-1:0]               issue_ctrl_i,
   input  logic [WARP_SIZE*3*DATA_W-1:0]   issue_data_i,
   output logic [NUM_LANES-1:0]            lane_valid_o,
   output logic [CTRL_W-1:0]               lane_ctrl_o,
   output logic [NUM_LANES*3*DATA_W-1:0]   lane_data_o,
   input  logic [NUM_LANES*DATA_W-1:0]     lane_result_i,
   output logic                            wb_valid_o,
   input  logic                            wb_ready_i,
   output logic [WARP_SIZE-1:0]            wb_mask_o,
   output logic [CTRL_W-1:0]               wb_ctrl_o,
   output logic [WARP_SIZE*DATA_W-1:0]     wb_result_o,
   output logic                            busy_o
);
   localparam int PASSES    = WARP_SIZE / NUM_LANES;
   localparam int PASS_W    = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam int GRP_OPS_W = NUM_LANES * 3 * DATA_W;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} seqState_t;

   seqState_t                     stateQ;
   logic [WARP_SIZE-1:0]          maskQ;
   logic [CTRL_W-1:0]             ctrlQ;
   logic [WARP_SIZE*3*DATA_W-1:0] dataQ;
   logic [WARP_SIZE*DATA_W-1:0]   resultQ;
   logic [PASSES-1:0]             pendingQ;

   logic [PASSES-1:0]    maskGroups;
   logic [PASSES-1:0]    pendingNext;
   logic [PASS_W-1:0]    curGroup;
   logic [NUM_LANES-1:0] groupValid;

   always_comb begin
      maskGroups = '0;
      for (int p = 0; p < PASSES; p++)
         maskGroups[p] = |issue_mask_i[p*NUM_LANES +: NUM_LANES];
   end

   // Descending scan so the lowest pending group wins.
   always_comb begin
      curGroup = '0;
      for (int p = PASSES - 1; p >= 0; p--)
         if (pendingQ[p]) curGroup = PASS_W'(p);
   end

   assign groupValid  = maskQ[int'(curGroup)*NUM_LANES +: NUM_LANES];
   assign pendingNext = pendingQ & ~(PASSES'(1) << curGroup);

   assign issue_ready_o = (stateQ == IDLE);
   assign busy_o        = (stateQ != IDLE);
   assign wb_valid_o    = (stateQ == DONE);
   assign lane_valid_o  = (stateQ == EXEC) ? groupValid : '0;
   assign lane_data_o   = dataQ[int'(curGroup)*GRP_OPS_W +: GRP_OPS_W];
   assign lane_ctrl_o   = ctrlQ;
   assign wb_ctrl_o     = ctrlQ;
   assign wb_mask_o     = maskQ;
   assign wb_result_o   = resultQ;

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ   <= IDLE;
         maskQ    <= '0;
         ctrlQ    <= '0;
         dataQ    <= '0;
         resultQ  <= '0;
         pendingQ <= '0;
      end else begin
         unique case (stateQ)
            IDLE: begin
               if (issue_valid_i) begin
                  maskQ    <= issue_mask_i;
                  ctrlQ    <= issue_ctrl_i;
                  dataQ    <= issue_data_i;
                  resultQ  <= '0;
                  pendingQ <= maskGroups;
                  stateQ   <= (maskGroups == '0) ? DONE : EXEC;
               end
            end
            EXEC: begin
               // Inactive threads are left at the zero written on acceptance.
               for (int l = 0; l < NUM_LANES; l++)
                  if (groupValid[l])
                     resultQ[(int'(curGroup)*NUM_LANES + l)*DATA_W +: DATA_W]
                        <= lane_result_i[l*DATA_W +: DATA_W];
               pendingQ <= pendingNext;
               if (pendingNext == '0) stateQ <= DONE;
            end
            DONE: begin
               if (wb_ready_i) stateQ <= IDLE;
            end
            default: stateQ <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_intu_warp_sequencer.sv
// Directed bench for intu_warp_sequencer: 8-lane default build plus a 32-lane build, with adder lane models.
module tb_intu_warp_sequencer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic           issueValid, issueReady;
   logic [31:0]    issueMask;
   logic [63:0]    issueCtrl;
   logic [3071:0]  issueData;
   logic [7:0]     laneValid;
   logic [63:0]    laneCtrl;
   logic [767:0]   laneData;
   logic [255:0]   laneResult;
   logic           wbValid, wbReady;
   logic [31:0]    wbMask;
   logic [63:0]    wbCtrl;
   logic [1023:0]  wbResult;
   logic           busy;

   logic           issueValid32, issueReady32;
   logic [31:0]    laneValid32;
   logic [63:0]    laneCtrl32;
   logic [3071:0]  laneData32;
   logic [1023:0]  laneResult32;
   logic           wbValid32, wbReady32;
   logic [31:0]    wbMask32;
   logic [63:0]    wbCtrl32;
   logic [1023:0]  wbResult32;
   logic           busy32;

   intu_warp_sequencer u_dut (
      .clk(clk), .reset(reset),
      .issue_valid_i(issueValid), .issue_ready_o(issueReady),
      .issue_mask_i(issueMask), .issue_ctrl_i(issueCtrl), .issue_data_i(issueData),
      .lane_valid_o(laneValid), .lane_ctrl_o(laneCtrl), .lane_data_o(laneData),
      .lane_result_i(laneResult),
      .wb_valid_o(wbValid), .wb_ready_i(wbReady), .wb_mask_o(wbMask),
      .wb_ctrl_o(wbCtrl), .wb_result_o(wbResult), .busy_o(busy)
   );

   intu_warp_sequencer #(.NUM_LANES(32)) u_dut32 (
      .clk(clk), .reset(reset),
      .issue_valid_i(issueValid32), .issue_ready_o(issueReady32),
      .issue_mask_i(issueMask), .issue_ctrl_i(issueCtrl), .issue_data_i(issueData),
      .lane_valid_o(laneValid32), .lane_ctrl_o(laneCtrl32), .lane_data_o(laneData32),
      .lane_result_i(laneResult32),
      .wb_valid_o(wbValid32), .wb_ready_i(wbReady32), .wb_mask_o(wbMask32),
      .wb_ctrl_o(wbCtrl32), .wb_result_o(wbResult32), .busy_o(busy32)
   );

   // Lanes execute an add: result = data1 + data2.
   always_comb begin
      laneResult = '0;
      for (int l = 0; l < 8; l++)
         laneResult[l*32 +: 32] = laneData[l*96 +: 32] + laneData[l*96+32 +: 32];
   end
   always_comb begin
      laneResult32 = '0;
      for (int l = 0; l < 32; l++)
         laneResult32[l*32 +: 32] = laneData32[l*96 +: 32] + laneData32[l*96+32 +: 32];
   end

   task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setData(input logic [31:0] addend);
      for (int t = 0; t < 32; t++) begin
         issueData[t*96 +: 32]    = 32'(t);
         issueData[t*96+32 +: 32] = addend;
         issueData[t*96+64 +: 32] = 32'hDEAD_0000 | 32'(t);
      end
   endtask

   task automatic doPacket(input logic [31:0] m, input logic [63:0] c,
                           input logic [31:0] addend, input int hold);
      logic [1023:0] expRes;
      expRes = '0;
      for (int t = 0; t < 32; t++)
         if (m[t]) expRes[t*32 +: 32] = 32'(t) + addend;
      setData(addend);
      issueMask  = m;
      issueCtrl  = c;
      issueValid = 1'b1;
      chk("issue_rdy_idle", 1024'(issueReady), 1024'(1));
      tick();
      issueValid = 1'b0;
      issueMask  = ~m;
      issueCtrl  = ~c;
      for (int g = 0; g < 4; g++) begin
         if (m[g*8 +: 8] != 8'h00) begin
            chk("lane_vld", 1024'(laneValid), 1024'(m[g*8 +: 8]));
            chk("lane_dat7", 1024'(laneData[7*96 +: 32]), 1024'(g*8 + 7));
            chk("wb_vld_exec", 1024'(wbValid), 1024'(0));
            chk("issue_rdy_exec", 1024'(issueReady), 1024'(0));
            tick();
         end
      end
      chk("wb_vld", 1024'(wbValid), 1024'(1));
      chk("lane_vld_done", 1024'(laneValid), 1024'(0));
      chk("wb_res", wbResult, expRes);
      chk("wb_mask", 1024'(wbMask), 1024'(m));
      chk("wb_ctrl", 1024'(wbCtrl), 1024'(c));
      chk("lane_ctrl", 1024'(laneCtrl), 1024'(c));
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("hold_wb_vld", 1024'(wbValid), 1024'(1));
         chk("hold_issue_rdy", 1024'(issueReady), 1024'(0));
         chk("hold_wb_res", wbResult, expRes);
         chk("hold_wb_ctrl", 1024'(wbCtrl), 1024'(c));
      end
      wbReady = 1'b1;
      tick();
      wbReady = 1'b0;
      chk("issue_rdy_after", 1024'(issueReady), 1024'(1));
      chk("wb_vld_after", 1024'(wbValid), 1024'(0));
      chk("busy_after", 1024'(busy), 1024'(0));
   endtask

   initial begin
      logic [1023:0] exp32;
      reset = 1'b1; issueValid = 1'b0; issueValid32 = 1'b0;
      wbReady = 1'b0; wbReady32 = 1'b0;
      issueMask = '0; issueCtrl = '0; issueData = '0;
      tick(); tick();
      reset = 1'b0;

      chk("rst_issue_rdy", 1024'(issueReady), 1024'(1));
      chk("rst_busy", 1024'(busy), 1024'(0));
      chk("rst_wb_vld", 1024'(wbValid), 1024'(0));
      chk("rst_lane_vld", 1024'(laneValid), 1024'(0));
      chk("rst_wb_mask", 1024'(wbMask), 1024'(0));
      chk("rst_wb_ctrl", 1024'(wbCtrl), 1024'(0));
      chk("rst_wb_res", wbResult, 1024'(0));

      doPacket(32'hFFFF_FFFF, 64'h0000_0001_0000_00AD, 32'd1, 0);
      doPacket(32'h00FF_0001, 64'h1234_5678_9ABC_DEF0, 32'd5, 0);
      doPacket(32'h0000_0000, 64'hCAFE_F00D_0000_0042, 32'd7, 0);
      doPacket(32'hFFFF_FFFF, 64'h0BAD_BEEF_0000_0011, 32'd3, 3);
      doPacket(32'h8001_0F00, 64'h0000_0000_5555_AAAA, 32'd9, 0);

      // Abort mid-EXEC: reset high during T+2.
      setData(32'd2);
      issueMask  = 32'hFFFF_FFFF;
      issueCtrl  = 64'h7777_0000_0000_7777;
      issueValid = 1'b1;
      tick();
      issueValid = 1'b0;
      chk("abort_busy_t1", 1024'(busy), 1024'(1));
      tick();
      chk("abort_wb_vld_t2", 1024'(wbValid), 1024'(0));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 1024'(busy), 1024'(0));
      chk("abort_issue_rdy", 1024'(issueReady), 1024'(1));
      chk("abort_wb_vld", 1024'(wbValid), 1024'(0));
      chk("abort_wb_res", wbResult, 1024'(0));
      chk("abort_lane_vld", 1024'(laneValid), 1024'(0));
      chk("abort_wb_ctrl", 1024'(wbCtrl), 1024'(0));
      doPacket(32'h0F0F_F0F0, 64'h0000_0000_0000_0ACE, 32'd11, 1);

      // 32-lane build, single top thread.
      setData(32'd4);
      issueMask    = 32'h8000_0000;
      issueCtrl    = 64'h0000_3232_0000_3232;
      chk("w32_issue_rdy", 1024'(issueReady32), 1024'(1));
      issueValid32 = 1'b1;
      tick();
      issueValid32 = 1'b0;
      chk("w32_lane_vld", 1024'(laneValid32), 1024'(32'h8000_0000));
      chk("w32_wb_vld_exec", 1024'(wbValid32), 1024'(0));
      tick();
      exp32 = '0;
      exp32[31*32 +: 32] = 32'd35;
      chk("w32_wb_vld", 1024'(wbValid32), 1024'(1));
      chk("w32_lane_vld_done", 1024'(laneValid32), 1024'(0));
      chk("w32_wb_res", wbResult32, exp32);
      chk("w32_wb_mask", 1024'(wbMask32), 1024'(32'h8000_0000));
      chk("w32_wb_ctrl", 1024'(wbCtrl32), 1024'(64'h0000_3232_0000_3232));
      chk("w32_lane_ctrl", 1024'(laneCtrl32), 1024'(64'h0000_3232_0000_3232));
      wbReady32 = 1'b1;
      tick();
      wbReady32 = 1'b0;
      chk("w32_issue_rdy_after", 1024'(issueReady32), 1024'(1));
      chk("w32_busy_after", 1024'(busy32), 1024'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
